// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared state encoding and output decode for the serial parity generator
package parity_pkg;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } parity_state_t;

  // sense=1 flags an odd count of ones (even-parity bit); sense=0 flags an even count.
  function automatic logic parity_out(input parity_state_t state, input bit sense);
    return sense ? (state == ODD) : (state == EVEN);
  endfunction

endpackage

// File: rtl/parity_gen_fsm.sv
// rtl/parity_gen_fsm.sv - serial running-parity generator/checker with optional fixed-length framing
module parity_gen_fsm
  import parity_pkg::*;
#(
  parameter bit ODD_SENSE = 1'b1,
  parameter int FRAME_LEN = 0,
  parameter int CNT_W     = 8
) (
  input  logic x,
  input  logic clk,
  output logic z,
  input  logic rst
);

  parity_state_t state_q, state_d;
  logic          frame_restart;

  // The edge after a frame's last bit folds that bit into a fresh frame, so each
  // completed-frame result stays on z for exactly one cycle.
  generate
    if (FRAME_LEN > 0) begin : g_frame
      localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_LEN);

      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        frame_restart = (cnt_q == FRAME_END);
        cnt_d         = frame_restart ? CNT_W'(1) : cnt_q + 1'b1;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end else begin : g_free
      assign frame_restart = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    if (frame_restart) begin
      state_d = parity_state_t'(x);
    end else begin
      state_d = parity_state_t'(state_q ^ x);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EVEN;
    end else begin
      state_q <= state_d;
    end
  end

  assign z = parity_out(state_q, ODD_SENSE);

endmodule

// File: tb/tb_parity_gen_fsm.sv
// tb/tb_parity_gen_fsm.sv - self-checking bench for parity_gen_fsm across several parameter sets
module tb_parity_gen_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic x   = 1'b0;
  logic z_def, z_even, z_f4, z_f5;

  int checks = 0;
  int errors = 0;

  // Reference model: bit count since reset and ones counts per accumulation window.
  int nbits   = 0;
  int ones    = 0;
  int f4_ones = 0;
  int f5_ones = 0;

  always #5 clk = ~clk;

  parity_gen_fsm u_def (.x(x), .clk(clk), .z(z_def), .rst(rst));

  parity_gen_fsm #(.ODD_SENSE(1'b0)) u_even (.x(x), .clk(clk), .z(z_even), .rst(rst));

  parity_gen_fsm #(.FRAME_LEN(4)) u_f4 (.x(x), .clk(clk), .z(z_f4), .rst(rst));

  parity_gen_fsm #(.FRAME_LEN(5), .CNT_W(3)) u_f5 (.x(x), .clk(clk), .z(z_f5), .rst(rst));

  function automatic logic ref_z(input int cnt, input bit sense);
    return ((cnt % 2) == 1) ? sense : !sense;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one bit, clock it in, advance the model, and compare every instance.
  task automatic step(input logic xi, input logic ri, input string tag);
    x   = xi;
    rst = ri;
    @(posedge clk);
    #1;
    if (ri) begin
      nbits   = 0;
      ones    = 0;
      f4_ones = 0;
      f5_ones = 0;
    end else begin
      if (nbits % 4 == 0) f4_ones = 0;
      if (nbits % 5 == 0) f5_ones = 0;
      ones    += int'(xi);
      f4_ones += int'(xi);
      f5_ones += int'(xi);
      nbits++;
    end
    check({tag, "_def"},  z_def,  ref_z(ones, 1'b1));
    check({tag, "_even"}, z_even, ref_z(ones, 1'b0));
    check({tag, "_f4"},   z_f4,   ref_z(f4_ones, 1'b1));
    check({tag, "_f5"},   z_f5,   ref_z(f5_ones, 1'b1));
  endtask

  logic [19:0] s2_bits;
  logic [19:0] s2_exp;
  logic [5:0]  s5_bits;
  logic [5:0]  s5_exp;

  initial begin
    // Reset held two edges with x=1: the ones must be discarded.
    step(1'b1, 1'b1, "rst0");
    step(1'b1, 1'b1, "rst1");
    check("rst_z_def",  z_def,  1'b0);
    check("rst_z_even", z_even, 1'b1);
    check("rst_z_f4",   z_f4,   1'b0);

    // Directed stream with literal expected parity, MSB first in the vectors.
    s2_bits = 20'b0111_0100_0110_1111_0000;
    s2_exp  = 20'b0101_1000_0100_1010_0000;
    for (int i = 19; i >= 0; i--) begin
      step(s2_bits[i], 1'b0, "s2");
      check("s2_tbl_def",  z_def,  s2_exp[i]);
      check("s2_tbl_even", z_even, ~s2_exp[i]);
    end

    // Reset in the middle of a stream discards the bit present on x.
    step(1'b0, 1'b1, "s3r");
    step(1'b1, 1'b0, "s3");
    step(1'b1, 1'b0, "s3");
    step(1'b1, 1'b0, "s3");
    check("s3_pre", z_def, 1'b1);
    step(1'b1, 1'b1, "s3r");
    check("s3_rst", z_def, 1'b0);
    step(1'b1, 1'b0, "s3");
    check("s3_post", z_def, 1'b1);

    // Four-bit frames: completed frame result, then a fresh frame.
    step(1'b0, 1'b1, "s5r");
    s5_bits = 6'b110110;
    s5_exp  = 6'b100111;
    for (int i = 5; i >= 0; i--) begin
      step(s5_bits[i], 1'b0, "s5");
      check("s5_tbl_f4", z_f4, s5_exp[i]);
    end

    // Long random run with occasional resets; covers 3-bit and 8-bit counter wrap.
    step(1'b0, 1'b1, "s6r");
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0), "s6");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
